// File: rtl/binary_to_gray_encoder_if.sv
// Strobed word bundle between a binary source and the Gray encoder.
// master drives inStrobe/dataIn; slave returns outStrobe/dataOut/adjacent/firstOut.
interface binary_to_gray_encoder_if #(
  parameter int WIDTH = 32
);
  logic             inStrobe;
  logic [WIDTH-1:0] dataIn;
  logic             outStrobe;
  logic [WIDTH-1:0] dataOut;
  logic             adjacent;
  logic             firstOut;

  modport master (
    output inStrobe, dataIn,
    input  outStrobe, dataOut, adjacent, firstOut
  );

  modport slave (
    input  inStrobe, dataIn,
    output outStrobe, dataOut, adjacent, firstOut
  );
endinterface

// File: rtl/binary_to_gray_encoder.sv
// Pipelined binary-to-Gray encoder with registered unit-distance flag.
// Ports: clk, rst (sync, active-high), bus (slave: strobe/data in, strobe/gray/flags out).
module binary_to_gray_encoder #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  binary_to_gray_encoder_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("binary_to_gray_encoder: WIDTH must be 2..64");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("binary_to_gray_encoder: LATENCY must be 1..4");
  end

  logic [WIDTH-1:0] gray_c;
  logic             fin_stb;
  logic [WIDTH-1:0] fin_gray;

  assign gray_c = bus.dataIn ^ (bus.dataIn >> 1);

  // LATENCY=1 folds the encode into the output stage.
  if (LATENCY == 1) begin : g_direct
    assign fin_stb  = bus.inStrobe;
    assign fin_gray = gray_c;
  end else begin : g_pipe
    localparam int D = LATENCY - 1;
    logic [D-1:0]     pipe_stb_q;
    logic [D-1:0]     pipe_stb_d;
    logic [WIDTH-1:0] pipe_gray_q [D];
    logic [WIDTH-1:0] pipe_gray_d [D];

    always_comb begin
      pipe_stb_d[0]  = bus.inStrobe;
      pipe_gray_d[0] = gray_c;
      for (int i = 1; i < D; i++) begin
        pipe_stb_d[i]  = pipe_stb_q[i-1];
        pipe_gray_d[i] = pipe_gray_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_stb_q <= '0;
        for (int i = 0; i < D; i++)
          pipe_gray_q[i] <= '0;
      end else begin
        pipe_stb_q <= pipe_stb_d;
        for (int i = 0; i < D; i++)
          pipe_gray_q[i] <= pipe_gray_d[i];
      end
    end

    assign fin_stb  = pipe_stb_q[D-1];
    assign fin_gray = pipe_gray_q[D-1];
  end

  logic             out_stb_q, out_stb_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             adj_q, adj_d;
  logic             first_q, first_d;
  logic             has_q, has_d;
  logic [WIDTH-1:0] diff;
  logic             one_bit;

  // data_q only changes on strobed outputs, so it doubles as prevGray.
  always_comb begin
    diff    = fin_gray ^ data_q;
    one_bit = (diff != '0) &&
              ((diff & (diff - WIDTH'(1))) == '0);
    out_stb_d = fin_stb;
    data_d    = data_q;
    adj_d     = adj_q;
    first_d   = first_q;
    has_d     = has_q;
    if (fin_stb) begin
      data_d  = fin_gray;
      adj_d   = has_q && one_bit;
      first_d = !has_q;
      has_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_stb_q <= 1'b0;
      data_q    <= '0;
      adj_q     <= 1'b0;
      first_q   <= 1'b0;
      has_q     <= 1'b0;
    end else begin
      out_stb_q <= out_stb_d;
      data_q    <= data_d;
      adj_q     <= adj_d;
      first_q   <= first_d;
      has_q     <= has_d;
    end
  end

  assign bus.outStrobe = out_stb_q;
  assign bus.dataOut   = data_q;
  assign bus.adjacent  = adj_q;
  assign bus.firstOut  = first_q;

endmodule

// File: tb/tb_binary_to_gray_encoder.sv
// Bench for binary_to_gray_encoder: four lanes with LATENCY 1..4 share stimulus.
// A per-edge history model predicts every output; literal checks pin lane LATENCY=2.
module tb_binary_to_gray_encoder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_stb;
  logic [W-1:0] din;

  logic [3:0]   os, oa, of_;
  logic [W-1:0] od [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    binary_to_gray_encoder_if #(.WIDTH(W)) bus ();
    assign bus.inStrobe = in_stb;
    assign bus.dataIn   = din;
    binary_to_gray_encoder #(
      .WIDTH(W), .LATENCY(g + 1)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign os[g]  = bus.outStrobe;
    assign od[g]  = bus.dataOut;
    assign oa[g]  = bus.adjacent;
    assign of_[g] = bus.firstOut;
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_gray(logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W; i++)
      g[i] = b[i] ^ ((i < W - 1) ? b[i+1] : 1'b0);
    return g;
  endfunction

  function automatic logic [W-1:0] from_gray(logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // history of what each edge sampled
  int           e = 0;
  bit           acc_h [16];
  bit           rst_h [16];
  logic [W-1:0] d_h   [16];

  logic         m_stb [4];
  logic [W-1:0] m_d   [4];
  logic         m_a   [4];
  logic         m_f   [4];
  logic         m_h   [4];
  int           src   [4];
  bit           v;

  typedef struct {
    logic [W-1:0] d;
    logic         a;
    logic         f;
  } rec_t;
  rec_t litq[$];

  always @(posedge clk) begin
    e++;
    acc_h[e % 16] = in_stb && !rst;
    rst_h[e % 16] = rst;
    d_h[e % 16]   = din;
    for (int l = 0; l < 4; l++) begin
      if (rst) begin
        m_stb[l] = 0; m_d[l] = '0; m_a[l] = 0;
        m_f[l] = 0; m_h[l] = 0;
      end else begin
        src[l] = e - l;
        v = (src[l] >= 1) && acc_h[src[l] % 16];
        for (int j = src[l] + 1; j <= e; j++)
          if (rst_h[j % 16]) v = 0;
        m_stb[l] = v;
        if (v) begin
          logic [W-1:0] g;
          g = to_gray(d_h[src[l] % 16]);
          m_a[l] = m_h[l] && ($countones(g ^ m_d[l]) == 1);
          m_f[l] = !m_h[l];
          m_d[l] = g;
          m_h[l] = 1;
        end
      end
    end
    #1;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("L%0d.stb", l + 1), 64'(os[l]), 64'(m_stb[l]));
      chk($sformatf("L%0d.data", l + 1), 64'(od[l]), 64'(m_d[l]));
      chk($sformatf("L%0d.adj", l + 1), 64'(oa[l]), 64'(m_a[l]));
      chk($sformatf("L%0d.first", l + 1), 64'(of_[l]), 64'(m_f[l]));
      if (os[l] && m_stb[l])
        chk($sformatf("L%0d.roundtrip", l + 1),
            64'(from_gray(od[l])), 64'(d_h[src[l] % 16]));
    end
    if (os[1]) litq.push_back('{od[1], oa[1], of_[1]});
  end

  task automatic strobe(input logic [W-1:0] val);
    @(negedge clk);
    in_stb = 1'b1;
    din    = val;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_stb = 1'b0;
      din    = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst    = 1'b1;
    in_stb = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    litq.delete();
  endtask

  task automatic lit(string nm, int i, logic [W-1:0] d,
                     logic a, logic f);
    if (i < litq.size()) begin
      chk({nm, ".data"}, 64'(litq[i].d), 64'(d));
      chk({nm, ".adj"}, 64'(litq[i].a), 64'(a));
      chk({nm, ".first"}, 64'(litq[i].f), 64'(f));
    end else
      chk({nm, ".count"}, 64'(litq.size()), 64'(i + 1));
  endtask

  initial begin
    rst    = 1'b1;
    in_stb = 1'b0;
    din    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.stb", 64'(os[1]), 64'd0);
    chk("reset.data", 64'(od[1]), 64'd0);
    chk("reset.adj", 64'(oa[1]), 64'd0);
    chk("reset.first", 64'(of_[1]), 64'd0);

    // single word, exact timing on the LATENCY=2 lane
    strobe(32'h5);
    @(negedge clk);
    in_stb = 1'b0;
    @(posedge clk); #1;
    chk("single.stb_at_k1", 64'(os[1]), 64'd1);
    chk("single.data", 64'(od[1]), 64'h7);
    chk("single.first", 64'(of_[1]), 64'd1);
    chk("single.adj", 64'(oa[1]), 64'd0);
    @(posedge clk); #1;
    chk("single.stb_drop", 64'(os[1]), 64'd0);
    chk("single.hold", 64'(od[1]), 64'h7);
    idle(3);

    do_reset(2);
    strobe(32'd5); strobe(32'd6);
    strobe(32'd7); strobe(32'd8);
    idle(6);
    chk("b2b.count", 64'(litq.size()), 64'd4);
    lit("b2b0", 0, 32'h7, 1'b0, 1'b1);
    lit("b2b1", 1, 32'h5, 1'b1, 1'b0);
    lit("b2b2", 2, 32'h4, 1'b1, 1'b0);
    lit("b2b3", 3, 32'hC, 1'b1, 1'b0);

    do_reset(2);
    strobe(32'd0); strobe(32'd3); strobe(32'd3);
    idle(6);
    chk("rep.count", 64'(litq.size()), 64'd3);
    lit("rep0", 0, 32'h0, 1'b0, 1'b1);
    lit("rep1", 1, 32'h2, 1'b1, 1'b0);
    lit("rep2", 2, 32'h2, 1'b0, 1'b0);

    do_reset(2);
    strobe(32'hFFFF_FFFF);
    strobe(32'h8000_0000);
    strobe(32'h7FFF_FFFF);
    idle(6);
    chk("msb.count", 64'(litq.size()), 64'd3);
    lit("msb0", 0, 32'h8000_0000, 1'b0, 1'b1);
    lit("msb1", 1, 32'hC000_0000, 1'b1, 1'b0);
    lit("msb2", 2, 32'h4000_0000, 1'b1, 1'b0);

    // second word is sampled on the reset edge and must be ignored
    do_reset(2);
    strobe(32'h10);
    @(negedge clk);
    in_stb = 1'b1;
    din    = 32'h11;
    rst    = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    in_stb = 1'b0;
    litq.delete();
    idle(6);
    chk("midrst.none", 64'(litq.size()), 64'd0);
    chk("midrst.stb", 64'(os[1]), 64'd0);
    chk("midrst.data", 64'(od[1]), 64'd0);
    chk("midrst.adj", 64'(oa[1]), 64'd0);
    chk("midrst.first", 64'(of_[1]), 64'd0);
    strobe(32'h12);
    idle(5);
    lit("midrst.next", 0, 32'h1B, 1'b0, 1'b1);

    for (int n = 0; n < 1024; n++) begin
      int unsigned wd;
      logic [W-1:0] r, mask;
      wd   = $urandom_range(3, W);
      mask = (wd == W) ? '1 : ((W'(1) << wd) - W'(1));
      r    = W'($urandom) & mask;
      strobe(r);
      if ($urandom_range(0, 2) == 0)
        idle($urandom_range(1, 3));
    end
    idle(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
